// File: rtl/di_regfile_pkg.sv
// Shared types and the write-port priority resolver for the dual-issue register file.
// The same resolver feeds both the commit path and the read bypass, so the two always agree.
package di_pkg;

   localparam int DI_REG_ADDR_W = 5;
   localparam int DI_REG_DATA_W = 32;
   localparam int DI_REG_N      = 2 ** DI_REG_ADDR_W;

   typedef logic [DI_REG_ADDR_W-1:0] di_reg_addr_t;
   typedef logic [DI_REG_DATA_W-1:0] di_reg_data_t;

   typedef struct packed {
      di_reg_addr_t addr;
      di_reg_data_t data;
      logic         we;
   } di_wport_t;

   typedef struct packed {
      logic         hit;
      di_reg_data_t data;
   } di_wres_t;

   // Youngest writer wins: issue2 b2, then issue1 ALU (b), then issue1 LSU (a); x0 never hits.
   function automatic di_wres_t di_wr_resolve(input di_wport_t    wp_a,
                                              input di_wport_t    wp_b,
                                              input di_wport_t    wp_b2,
                                              input di_reg_addr_t idx);
      di_wres_t res;
      res.hit  = 1'b0;
      res.data = {DI_REG_DATA_W{1'b0}};
      if (idx == {DI_REG_ADDR_W{1'b0}}) begin
         res.hit = 1'b0;
      end else if (wp_b2.we && (wp_b2.addr == idx)) begin
         res.hit  = 1'b1;
         res.data = wp_b2.data;
      end else if (wp_b.we && (wp_b.addr == idx)) begin
         res.hit  = 1'b1;
         res.data = wp_b.data;
      end else if (wp_a.we && (wp_a.addr == idx)) begin
         res.hit  = 1'b1;
         res.data = wp_a.data;
      end else begin
         res.hit = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/di_regfile_rport.sv
// One combinational read port: x0 forced to zero, optional bypass from the winning write.
module di_regfile_rport
   import di_pkg::*;
#(
   parameter int BYPASS_EN = 1
) (
   input  di_reg_addr_t i_raddr,
   input  di_reg_data_t i_regs [DI_REG_N],
   input  di_wport_t    i_wp_a,
   input  di_wport_t    i_wp_b,
   input  di_wport_t    i_wp_b2,
   output di_reg_data_t o_rdata
);

   di_wres_t w_res;

   // Read mux with same-cycle forwarding.
   always_comb begin
      w_res = di_wr_resolve(i_wp_a, i_wp_b, i_wp_b2, i_raddr);
      if (i_raddr == {DI_REG_ADDR_W{1'b0}}) begin
         o_rdata = {DI_REG_DATA_W{1'b0}};
      end else if ((BYPASS_EN != 0) && w_res.hit) begin
         o_rdata = w_res.data;
      end else begin
         o_rdata = i_regs[i_raddr];
      end
   end

endmodule

// File: rtl/di_regfile.sv
// Dual-issue integer register file: four combinational read ports, three prioritised
// synchronous write ports, and a registered same-register write collision flag.
module di_regfile
   import di_pkg::*;
#(
   parameter int ADDR_WIDTH = DI_REG_ADDR_W,
   parameter int DATA_WIDTH = DI_REG_DATA_W,
   parameter int BYPASS_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   output logic [DATA_WIDTH-1:0] rdata_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic [DATA_WIDTH-1:0] rdata_b,
   input  logic [ADDR_WIDTH-1:0] raddr_a2,
   output logic [DATA_WIDTH-1:0] rdata_a2,
   input  logic [ADDR_WIDTH-1:0] raddr_b2,
   output logic [DATA_WIDTH-1:0] rdata_b2,
   input  logic [ADDR_WIDTH-1:0] waddr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] waddr_b,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] waddr_b2,
   input  logic [DATA_WIDTH-1:0] wdata_b2,
   input  logic                  we_b2,
   output logic                  wr_collision
);

   di_reg_data_t r_regs [DI_REG_N];
   di_reg_data_t w_next [DI_REG_N];
   di_wport_t    w_wp_a, w_wp_b, w_wp_b2;
   di_wres_t     w_res;
   logic         w_coll;
   logic         r_collision;

   assign w_wp_a  = '{addr: waddr_a,  data: wdata_a,  we: we_a};
   assign w_wp_b  = '{addr: waddr_b,  data: wdata_b,  we: we_b};
   assign w_wp_b2 = '{addr: waddr_b2, data: wdata_b2, we: we_b2};

   // Next-state per register from the shared priority resolver; x0 stays zero.
   always_comb begin
      w_res     = '{hit: 1'b0, data: {DI_REG_DATA_W{1'b0}}};
      w_next[0] = {DI_REG_DATA_W{1'b0}};
      for (int i = 1; i < DI_REG_N; i++) begin
         w_res = di_wr_resolve(w_wp_a, w_wp_b, w_wp_b2, di_reg_addr_t'(i));
         if (w_res.hit) begin
            w_next[i] = w_res.data;
         end else begin
            w_next[i] = r_regs[i];
         end
      end
   end

   // Pairwise same-target detection, excluding x0.
   always_comb begin
      w_coll = (we_a && we_b  && (waddr_a == waddr_b)  && (waddr_a != {ADDR_WIDTH{1'b0}}))
             | (we_a && we_b2 && (waddr_a == waddr_b2) && (waddr_a != {ADDR_WIDTH{1'b0}}))
             | (we_b && we_b2 && (waddr_b == waddr_b2) && (waddr_b != {ADDR_WIDTH{1'b0}}));
   end

   // Storage and collision flag; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DI_REG_N; i++) begin
            r_regs[i] <= {DI_REG_DATA_W{1'b0}};
         end
         r_collision <= 1'b0;
      end else begin
         for (int i = 0; i < DI_REG_N; i++) begin
            r_regs[i] <= w_next[i];
         end
         r_collision <= w_coll;
      end
   end

   assign wr_collision = r_collision;

   di_regfile_rport #(.BYPASS_EN(BYPASS_EN)) u_rport_a (
      .i_raddr(raddr_a), .i_regs(r_regs), .i_wp_a(w_wp_a), .i_wp_b(w_wp_b),
      .i_wp_b2(w_wp_b2), .o_rdata(rdata_a)
   );
   di_regfile_rport #(.BYPASS_EN(BYPASS_EN)) u_rport_b (
      .i_raddr(raddr_b), .i_regs(r_regs), .i_wp_a(w_wp_a), .i_wp_b(w_wp_b),
      .i_wp_b2(w_wp_b2), .o_rdata(rdata_b)
   );
   di_regfile_rport #(.BYPASS_EN(BYPASS_EN)) u_rport_a2 (
      .i_raddr(raddr_a2), .i_regs(r_regs), .i_wp_a(w_wp_a), .i_wp_b(w_wp_b),
      .i_wp_b2(w_wp_b2), .o_rdata(rdata_a2)
   );
   di_regfile_rport #(.BYPASS_EN(BYPASS_EN)) u_rport_b2 (
      .i_raddr(raddr_b2), .i_regs(r_regs), .i_wp_a(w_wp_a), .i_wp_b(w_wp_b),
      .i_wp_b2(w_wp_b2), .o_rdata(rdata_b2)
   );

endmodule

// File: tb/tb_di_regfile.sv
// Scoreboard bench for di_regfile: one bypassing and one non-bypassing instance share stimulus.
module tb_di_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  raddr_a = 5'd0, raddr_b = 5'd0, raddr_a2 = 5'd0, raddr_b2 = 5'd0;
   logic [4:0]  waddr_a = 5'd0, waddr_b = 5'd0, waddr_b2 = 5'd0;
   logic [31:0] wdata_a = 32'd0, wdata_b = 32'd0, wdata_b2 = 32'd0;
   logic        we_a = 1'b0, we_b = 1'b0, we_b2 = 1'b0;
   logic [31:0] rd_a [2], rd_b [2], rd_a2 [2], rd_b2 [2];
   logic        coll [2];

   typedef struct {
      int          cyc;
      int          dut;
      int          sig;
      logic [31:0] val;
      string       nm;
   } exp_t;

   exp_t        sb [$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] mon_got;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   di_regfile #(.BYPASS_EN(1)) u_byp (
      .clk(clk), .rst(rst),
      .raddr_a(raddr_a), .rdata_a(rd_a[0]), .raddr_b(raddr_b), .rdata_b(rd_b[0]),
      .raddr_a2(raddr_a2), .rdata_a2(rd_a2[0]), .raddr_b2(raddr_b2), .rdata_b2(rd_b2[0]),
      .waddr_a(waddr_a), .wdata_a(wdata_a), .we_a(we_a),
      .waddr_b(waddr_b), .wdata_b(wdata_b), .we_b(we_b),
      .waddr_b2(waddr_b2), .wdata_b2(wdata_b2), .we_b2(we_b2),
      .wr_collision(coll[0])
   );

   di_regfile #(.BYPASS_EN(0)) u_nob (
      .clk(clk), .rst(rst),
      .raddr_a(raddr_a), .rdata_a(rd_a[1]), .raddr_b(raddr_b), .rdata_b(rd_b[1]),
      .raddr_a2(raddr_a2), .rdata_a2(rd_a2[1]), .raddr_b2(raddr_b2), .rdata_b2(rd_b2[1]),
      .waddr_a(waddr_a), .wdata_a(wdata_a), .we_a(we_a),
      .waddr_b(waddr_b), .wdata_b(wdata_b), .we_b(we_b),
      .waddr_b2(waddr_b2), .wdata_b2(wdata_b2), .we_b2(we_b2),
      .wr_collision(coll[1])
   );

   function automatic logic [31:0] act(input int d, input int s);
      case (s)
         0:       return rd_a[d];
         1:       return rd_b[d];
         2:       return rd_a2[d];
         3:       return rd_b2[d];
         default: return {31'd0, coll[d]};
      endcase
   endfunction

   // Monitor: every falling edge, retire the expectations due this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            mon_got = act(sb[i].dut, sb[i].sig);
            checks++;
            if (sb[i].cyc < cyc || mon_got !== sb[i].val) begin
               failures++;
               $display("FAIL %s (dut%0d sig%0d cyc%0d): got %h expected %h",
                        sb[i].nm, sb[i].dut, sb[i].sig, cyc, mon_got, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp1(input int d, input int s, input logic [31:0] v, input int dly,
                       input string nm);
      exp_t e;
      e.cyc = cyc + dly; e.dut = d; e.sig = s; e.val = v; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic exp2(input int s, input logic [31:0] v, input string nm);
      exp1(0, s, v, 0, nm);
      exp1(1, s, v, 0, nm);
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] a2,
                     input logic [4:0] b2);
      raddr_a = a; raddr_b = b; raddr_a2 = a2; raddr_b2 = b2;
   endtask

   task automatic wclr();
      we_a = 1'b0; we_b = 1'b0; we_b2 = 1'b0;
   endtask

   task automatic wr(input int p, input logic [4:0] ad, input logic [31:0] dt);
      case (p)
         0:       begin waddr_a = ad;  wdata_a = dt;  we_a = 1'b1;  end
         1:       begin waddr_b = ad;  wdata_b = dt;  we_b = 1'b1;  end
         default: begin waddr_b2 = ad; wdata_b2 = dt; we_b2 = 1'b1; end
      endcase
   endtask

   initial begin
      // Reset state
      step();
      rd(5'd1, 5'd2, 5'd3, 5'd31);
      for (int s = 0; s < 5; s++) exp2(s, 32'd0, "reset_state");
      step();
      rst = 1'b0;

      // Triple distinct write, plus same-cycle bypass on port a
      step();
      wr(0, 5'd1, 32'h11); wr(1, 5'd2, 32'h22); wr(2, 5'd3, 32'h33);
      rd(5'd1, 5'd0, 5'd0, 5'd0);
      exp1(0, 0, 32'h11, 0, "triple_byp_a");
      exp1(1, 0, 32'h0,  0, "triple_nobyp_a");
      step();
      wclr(); rd(5'd1, 5'd2, 5'd3, 5'd3);
      exp2(0, 32'h11, "triple_x1"); exp2(1, 32'h22, "triple_x2");
      exp2(2, 32'h33, "triple_x3"); exp2(3, 32'h33, "triple_x3_b2");
      exp2(4, 32'd0, "triple_nocoll");
      #1;
      checks++;
      if (rd_a[0] !== 32'h11 || rd_a[1] !== 32'h11) begin
         failures++;
         $display("FAIL direct_triple_x1: got %h/%h", rd_a[0], rd_a[1]);
      end
      checks++;
      if (rd_b[0] !== 32'h22 || rd_b[1] !== 32'h22) begin
         failures++;
         $display("FAIL direct_triple_x2: got %h/%h", rd_b[0], rd_b[1]);
      end
      checks++;
      if (rd_a2[0] !== 32'h33 || rd_a2[1] !== 32'h33) begin
         failures++;
         $display("FAIL direct_triple_x3: got %h/%h", rd_a2[0], rd_a2[1]);
      end

      // Three-way collision on x7
      step();
      wr(0, 5'd7, 32'hA); wr(1, 5'd7, 32'hB); wr(2, 5'd7, 32'hC);
      rd(5'd7, 5'd7, 5'd0, 5'd0);
      exp1(0, 0, 32'hC, 0, "coll3_byp");
      exp1(1, 0, 32'h0, 0, "coll3_nobyp");
      exp2(4, 32'd0, "coll3_flag_early");
      step();
      wclr();
      exp2(0, 32'hC, "coll3_x7"); exp2(4, 32'd1, "coll3_flag");
      #1;
      checks++;
      if (rd_a[0] !== 32'hC || rd_a[1] !== 32'hC) begin
         failures++;
         $display("FAIL direct_coll3_x7: got %h/%h", rd_a[0], rd_a[1]);
      end
      step();
      exp2(4, 32'd0, "coll3_flag_drop");

      // Collision without b2: ALU beats LSU
      wr(0, 5'd7, 32'hA); wr(1, 5'd7, 32'hB);
      rd(5'd7, 5'd7, 5'd7, 5'd7);
      exp1(0, 3, 32'hB, 0, "coll2_byp");
      exp1(1, 3, 32'hC, 0, "coll2_nobyp_old");
      step();
      wclr();
      exp2(1, 32'hB, "coll2_x7"); exp2(4, 32'd1, "coll2_flag");
      step();
      exp2(4, 32'd0, "coll2_flag_drop");

      // Bypass from b2 while reading x9 on port a
      step();
      wr(2, 5'd9, 32'h55); rd(5'd9, 5'd9, 5'd9, 5'd9);
      exp1(0, 0, 32'h55, 0, "byp_a_same");
      exp1(0, 2, 32'h55, 0, "byp_a2_same");
      exp1(1, 0, 32'h0,  0, "nobyp_a_same");
      step();
      wclr();
      exp2(0, 32'h55, "byp_next");

      // x0 writes, including a collision on x0
      step();
      wr(2, 5'd0, 32'hFFFF_FFFF); wr(0, 5'd0, 32'h1); rd(5'd0, 5'd0, 5'd0, 5'd0);
      for (int s = 0; s < 4; s++) exp2(s, 32'd0, "x0_same");
      step();
      wclr();
      for (int s = 0; s < 5; s++) exp2(s, 32'd0, "x0_next");

      // Mid-cycle reset with writes pending
      step();
      wr(1, 5'd5, 32'hDEAD_BEEF);
      step();
      wclr(); rd(5'd5, 5'd5, 5'd5, 5'd5);
      exp2(0, 32'hDEAD_BEEF, "pre_reset_x5");
      step();
      rd(5'd0, 5'd0, 5'd0, 5'd0);
      wr(0, 5'd5, 32'h1234); wr(1, 5'd5, 32'h5678);
      #2;
      rst = 1'b1;
      step();
      wclr(); rd(5'd5, 5'd5, 5'd5, 5'd5);
      for (int s = 0; s < 5; s++) exp2(s, 32'd0, "reset_mid");
      #1;
      checks++;
      if (rd_b2[0] !== 32'd0 || rd_b2[1] !== 32'd0) begin
         failures++;
         $display("FAIL direct_reset_mid_x5: got %h/%h", rd_b2[0], rd_b2[1]);
      end
      step();
      rst = 1'b0;
      step();
      for (int s = 0; s < 5; s++) exp2(s, 32'd0, "reset_after");

      step();
      step();
      while (sb.size() > 0) begin
         failures++;
         $display("FAIL %s: never checked, expected %h", sb[0].nm, sb[0].val);
         void'(sb.pop_front());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
